data_mem_store: RTL and testbench
=================================

# data_mem_store

Store-side write engine for the byte-addressed data memory. Accepts byte/halfword/word store requests from the core over a valid/ready handshake and buffers them in a small FIFO. It then drains each entry into the memory's byte-wide write port, one byte per cycle, in little-endian order. This order matches the memory's load path, which assembles `{mem[a+3], mem[a+2], mem[a+1], mem[a]}`.

## Interface
- `DEPTH`, 4: store FIFO entries; power of two, ≥2.
- `MEM_SIZE`, 100: data memory size in bytes; byte addresses ≥ `MEM_SIZE` are never written.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: FIFO can accept; equals `count != DEPTH`.
- `st_addr` in 32: byte address of the store.
- `st_data` in 32: store data, right-aligned.
- `st_mode` in 3: `000` BYTE, `001` HALFWORD, `010` WORD; any other value is illegal.
- `mem_wr_en` out 1: byte write strobe to data memory.
- `mem_addr` out 32: byte address for the write.
- `mem_wdata` out 8: byte to write.
- `busy` out 1: `state == WRITE || count != 0`.
- `err` out 1: one-cycle pulse flagging a rejected request.
- `count` out `$clog2(DEPTH+1)`: FIFO occupancy.

## Operation
- **Accept:** `st_valid && st_ready` at a rising edge.
  - Legal request: pushes `{addr, data, nbytes}`, where `nbytes` = 1/2/4 for BYTE/HALFWORD/WORD.
  - Rejected request: handshake completes, nothing is pushed, `err` is high for the following cycle.
  - Always rejected: illegal `st_mode`.
- **FSM states:** IDLE, WRITE.
  - IDLE, FIFO non-empty: pop head into working registers (`base`, `data`, `nbytes`), set `idx = 0`, go to WRITE.
  - WRITE, each cycle: `mem_addr = base + idx`, `mem_wdata = data[8*idx +: 8]`, `mem_wr_en = (base + idx < MEM_SIZE)`.
  - WRITE, when `idx != nbytes-1`: `idx` increments.
  - WRITE, on the last byte: if the FIFO is non-empty, pop the next head and stay in WRITE with no bubble; otherwise go to IDLE.
- **Pop:** happens at working-register load, freeing the slot immediately.
- **Arithmetic:** `base + idx` is 32-bit and wraps modulo 2^32. Upper `st_data` bits beyond `nbytes` are ignored.
- **Out-of-range bytes:** each still consumes its cycle with `mem_wr_en = 0`; no `err`.
- **Simultaneous push and pop:** `count` is unchanged. When full, no push occurs even if a pop happens the same edge, because `st_ready` is computed from the current `count`. No bypass.
- **Pointers:** read/write pointers wrap modulo `DEPTH`.

## Timing
- **Reset values:** `count` 0, pointers 0, state IDLE, `mem_wr_en` 0, `mem_addr` 0, `mem_wdata` 0, `err` 0.
  - Derived from these: `st_ready` 1, `busy` 0.
- **Reset mid-store:** remaining bytes and FIFO contents are discarded. Bytes already written stay in memory.
- **Outputs:** `mem_*` are decoded from registered state and working registers, with no combinational path from `st_*`.
- **Latency:** request accepted at edge N into an empty, idle unit is popped at edge N+1. Byte k is presented during the cycle after edge N+1+k and written at edge N+2+k.
- **Throughput:** sustained back-to-back stores take exactly `nbytes` cycles each.
- **`err`:** registered; high only for the cycle after the rejecting edge.

## Configuration
- `MISALIGN_CHK_EN` defined: a request is rejected with an `err` pulse when either:
  - HALFWORD with `st_addr[0] != 0`, or
  - WORD with `st_addr[1:0] != 0`.
- Not defined: misaligned stores are accepted and written byte-wise at `base..base+nbytes-1`.

## Test plan
- WORD, addr `0x10`, data `0x11223344`, idle unit:
  - Bytes `0x44@16`, `0x33@17`, `0x22@18`, `0x11@19` on consecutive cycles.
  - First byte written 2 edges after accept.
  - `busy` falls the cycle after the last byte.
- HALFWORD `0xAABBCCDD` @20 then BYTE `0x5A` @30, back-to-back:
  - Writes `0xDD@20`, `0xCC@21`, `0x5A@30` in 3 consecutive cycles.
  - Memory at 22 is untouched.
- DEPTH=4, `st_valid` held high with 6 WORD requests:
  - `st_ready` drops once `count` reaches 4.
  - All 24 bytes are written in order with no lost or duplicated request.
- `st_mode = 011`: `err` pulses one cycle, `count` stays 0, no `mem_wr_en`.
- WORD @98 with `MEM_SIZE = 100`:
  - Bytes 98 and 99 are written.
  - Cycles 3–4 present addr 100/101 with `mem_wr_en = 0`.
  - No `err`.
- HALFWORD @`0x11`:
  - With `MISALIGN_CHK_EN`: `err` pulses, no writes.
  - Without it: writes @17 and @18.
  - Separately, `rst` asserted after the 2nd byte of a WORD: outputs return to reset values immediately, and the remaining bytes are never written.

Source files
------------

// File: rtl/data_mem_store.sv
// data_mem_store: buffers byte/halfword/word store requests in a small FIFO
// and drains each one into the data memory's byte-wide write port, one byte
// per cycle, little-endian (lowest address receives data[7:0]).
// Optional feature macro: MISALIGN_CHK_EN (reject misaligned HALFWORD/WORD).
module data_mem_store #(
  parameter int DEPTH    = 4,
  parameter int MEM_SIZE = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 st_mode,
  output logic                       mem_wr_en,
  output logic [31:0]                mem_addr,
  output logic [7:0]                 mem_wdata,
  output logic                       busy,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] MODE_BYTE = 3'b000;
  localparam logic [2:0] MODE_HALF = 3'b001;
  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state, state_next;

  // FIFO storage and bookkeeping
  logic [31:0]   fifo_addr  [DEPTH];
  logic [31:0]   fifo_data  [DEPTH];
  logic [2:0]    fifo_nbyte [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Working registers of the store currently being drained
  logic [31:0] base;
  logic [31:0] wdata;
  logic [2:0]  nbytes;
  logic [1:0]  idx;

  logic        req_legal;
  logic [2:0]  req_nbytes;
  logic        accept, push, pop;
  logic        fifo_nempty, last_byte;
  logic [31:0] byte_addr;

  assign st_ready    = (count != CW'(DEPTH));
  assign accept      = st_valid && st_ready;
  assign push        = accept && req_legal;
  assign fifo_nempty = (count != '0);
  assign last_byte   = ({1'b0, idx} == (nbytes - 3'd1));
  assign pop         = fifo_nempty && ((state == IDLE) || last_byte);
  assign busy        = (state == WRITE) || fifo_nempty;
  assign byte_addr   = base + {30'd0, idx};

  // Decode request size and legality from the incoming mode/address
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    req_legal  = 1'b1;
    req_nbytes = 3'd1;
    case (st_mode)
      MODE_BYTE: req_nbytes = 3'd1;
      MODE_HALF: req_nbytes = 3'd2;
      MODE_WORD: req_nbytes = 3'd4;
      default:   req_legal  = 1'b0;
    endcase
`ifdef MISALIGN_CHK_EN
    if (st_mode == MODE_HALF && st_addr[0])          req_legal = 1'b0;
    if (st_mode == MODE_WORD && st_addr[1:0] != 2'b00) req_legal = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: leave WRITE only when the last byte goes out and nothing is queued
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_nempty) state_next = WRITE;
      WRITE:   if (last_byte && !fifo_nempty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from registered state and working registers only
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = byte_addr;
      mem_wdata = wdata[{idx, 3'b000} +: 8];
      mem_wr_en = (byte_addr < 32'(MEM_SIZE));
    end
  end

  // FIFO payload write
  always_ff @(posedge clk) begin
    // NOTE: the payload array is not reset; occupancy (count/pointers) alone decides validity.
    if (push) begin
      fifo_addr[wr_ptr]  <= st_addr;
      fifo_data[wr_ptr]  <= st_data;
      fifo_nbyte[wr_ptr] <= req_nbytes;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Working registers: load on pop, otherwise step through the bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base   <= '0;
      wdata  <= '0;
      nbytes <= '0;
      idx    <= '0;
    end else if (pop) begin
      base   <= fifo_addr[rd_ptr];
      wdata  <= fifo_data[rd_ptr];
      nbytes <= fifo_nbyte[rd_ptr];
      idx    <= '0;
    end else if (state == WRITE && !last_byte) begin
      idx    <= idx + 2'd1;
    end
  end

  // Error pulse for a request that completed the handshake but was rejected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= accept && !req_legal;
  end

endmodule

// File: tb/tb_data_mem_store.sv
// Self-checking bench for data_mem_store: scoreboard of expected byte writes,
// plus per-scenario cycle-level checks. Honours MISALIGN_CHK_EN if defined.
module tb_data_mem_store;

  localparam int DEPTH    = 4;
  localparam int MEM_SIZE = 100;
  localparam int CW       = $clog2(DEPTH + 1);

  localparam logic [2:0] M_BYTE = 3'b000;
  localparam logic [2:0] M_HALF = 3'b001;
  localparam logic [2:0] M_WORD = 3'b010;

  logic          clk;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_mode;
  logic          mem_wr_en;
  logic [31:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          err;
  logic [CW-1:0] count;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tb_mem [128];
  int         total;
  int         bad;
  bit         saw_full;

  data_mem_store #(.DEPTH(DEPTH), .MEM_SIZE(MEM_SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_mode   (st_mode),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every byte strobe must match the next expected write
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %02h@%0d, required no write", mem_wdata, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          bad++;
          $display("FAIL sb_write: got %02h@%0d, required %02h@%0d", mem_wdata, mem_addr, e.data, e.addr);
        end
      end
      if (mem_addr < 128) tb_mem[mem_addr[6:0]] = mem_wdata;
    end
  end

  // Reference legality/size model of a request
  function automatic int req_bytes(input logic [31:0] a, input logic [2:0] m);
    int n;
    case (m)
      M_BYTE:  n = 1;
      M_HALF:  n = 2;
      M_WORD:  n = 4;
      default: n = 0;
    endcase
`ifdef MISALIGN_CHK_EN
    if (m == M_HALF && a[0] != 1'b0)    n = 0;
    if (m == M_WORD && a[1:0] != 2'b00) n = 0;
`endif
    return n;
  endfunction

  // Present a request at a negedge, wait (bounded) for ready, complete it at the posedge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    int n;
    int nb;
    wr_t e;
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mode  = m;
    n = 0;
    while (!st_ready && n < 100) begin
      if (count == CW'(DEPTH)) saw_full = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: st_ready=%0b, required 1 within 100 cycles", st_ready);
    end
    nb = req_bytes(a, m);
    for (int k = 0; k < nb; k++) begin
      e.addr = a + 32'(k);
      e.data = d[8*k +: 8];
      if (e.addr < MEM_SIZE) exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout: busy=%0b, required 0", name, busy);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (count !== '0 || st_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: count=%0d ready=%0b busy=%0b err=%0b, required 0 1 0 0", count, st_ready, busy, err);
    end
    total++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
      bad++;
      $display("FAIL reset_mem: wr_en=%0b addr=%0h wdata=%0h, required 0 0 0", mem_wr_en, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_timing();
    logic [31:0] w;
    w = 32'h1122_3344;
    send(32'h10, w, M_WORD);
    drop_valid();
    total++;
    if (mem_wr_en !== 1'b0 || busy !== 1'b1 || count !== CW'(1)) begin
      bad++;
      $display("FAIL word_queued: wr_en=%0b busy=%0b count=%0d, required 0 1 1", mem_wr_en, busy, count);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 32'(16 + k) || mem_wdata !== w[8*k +: 8]) begin
        bad++;
        $display("FAIL word_byte%0d: wr_en=%0b %02h@%0d, required 1 %02h@%0d",
                 k, mem_wr_en, mem_wdata, mem_addr, w[8*k +: 8], 16 + k);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL word_busy_fall: busy=%0b wr_en=%0b, required 0 0", busy, mem_wr_en);
    end
    wait_idle("word");
  endtask

  task automatic test_back_to_back();
    send(32'd20, 32'hAABB_CCDD, M_HALF);
    send(32'd30, 32'h0000_005A, M_BYTE);
    drop_valid();
    total++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'd20 || mem_wdata !== 8'hDD) begin
      bad++;
      $display("FAIL b2b_c0: wr_en=%0b %02h@%0d, required 1 dd@20", mem_wr_en, mem_wdata, mem_addr);
    end
    @(negedge clk);
    total++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'd21 || mem_wdata !== 8'hCC) begin
      bad++;
      $display("FAIL b2b_c1: wr_en=%0b %02h@%0d, required 1 cc@21", mem_wr_en, mem_wdata, mem_addr);
    end
    @(negedge clk);
    total++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'd30 || mem_wdata !== 8'h5A) begin
      bad++;
      $display("FAIL b2b_c2: wr_en=%0b %02h@%0d, required 1 5a@30", mem_wr_en, mem_wdata, mem_addr);
    end
    wait_idle("b2b");
    total++;
    if (tb_mem[22] !== 8'h00) begin
      bad++;
      $display("FAIL b2b_mem22: got %02h, required 00", tb_mem[22]);
    end
  endtask

  task automatic test_fill();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) send(32'(64 + 4 * i), $urandom, M_WORD);
    drop_valid();
    total++;
    if (saw_full !== 1'b1) begin
      bad++;
      $display("FAIL fill_ready: saw st_ready low at count=4 flag=%0b, required 1", saw_full);
    end
    wait_idle("fill");
  endtask

  task automatic test_illegal();
    send(32'd40, 32'hDEAD_BEEF, 3'b011);
    drop_valid();
    total++;
    if (err !== 1'b1 || count !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal_err: err=%0b count=%0d busy=%0b, required 1 0 0", err, count, busy);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: err=%0b, required 0", err);
    end
    wait_idle("illegal");
  endtask

  task automatic test_out_of_range();
    send(32'd98, 32'hA1B2_C3D4, M_WORD);
    drop_valid();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (mem_addr !== 32'(98 + k) || mem_wr_en !== (k < 2) || err !== 1'b0) begin
        bad++;
        $display("FAIL oor_c%0d: addr=%0d wr_en=%0b err=%0b, required %0d %0b 0",
                 k, mem_addr, mem_wr_en, err, 98 + k, (k < 2));
      end
    end
    wait_idle("oor");
  endtask

  task automatic test_misalign();
    logic [7:0] e17;
    logic [7:0] e18;
    logic       e_err;
`ifdef MISALIGN_CHK_EN
    e17 = 8'h33; e18 = 8'h22; e_err = 1'b1;
`else
    e17 = 8'hEF; e18 = 8'hBE; e_err = 1'b0;
`endif
    send(32'h11, 32'h0000_BEEF, M_HALF);
    drop_valid();
    total++;
    if (err !== e_err) begin
      bad++;
      $display("FAIL misalign_err: err=%0b, required %0b", err, e_err);
    end
    wait_idle("misalign");
    total++;
    if (tb_mem[17] !== e17 || tb_mem[18] !== e18) begin
      bad++;
      $display("FAIL misalign_mem: got %02h %02h, required %02h %02h", tb_mem[17], tb_mem[18], e17, e18);
    end
  endtask

  task automatic test_reset_mid();
    send(32'd60, 32'h0A0B_0C0D, M_WORD);
    drop_valid();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0 || err !== 1'b0 ||
        count !== '0 || busy !== 1'b0 || st_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_outputs: wr_en=%0b addr=%0h wdata=%0h err=%0b count=%0d busy=%0b ready=%0b, required 0 0 0 0 0 0 1",
               mem_wr_en, mem_addr, mem_wdata, err, count, busy, st_ready);
    end
    total++;
    if (exp_q.size() != 2) begin
      bad++;
      $display("FAIL rstmid_progress: %0d bytes pending at reset, required 2", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (tb_mem[60] !== 8'h0D || tb_mem[61] !== 8'h0C || tb_mem[62] !== 8'h00 || tb_mem[63] !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_mem: got %02h %02h %02h %02h, required 0d 0c 00 00",
               tb_mem[60], tb_mem[61], tb_mem[62], tb_mem[63]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    saw_full = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_mode  = '0;
    for (int i = 0; i < 128; i++) tb_mem[i] = 8'h00;
    test_reset();
    test_word_timing();
    test_back_to_back();
    test_fill();
    test_illegal();
    test_out_of_range();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
